// File: rtl/ethernet_multi_timer_pkg.sv
// rtl/ethernet_multi_timer_pkg.sv - register map, bit indices and address sizing for the multi-channel timer
package ethernet_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAPSHOT = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_IRQ_PEND = 3'd7;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Word address is {channel, reg[2:0]}; a single channel still needs the 3 reg bits.
  function automatic int addr_w(input int num_ch);
    return 3 + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/ethernet_multi_timer_if.sv
// rtl/ethernet_multi_timer_if.sv - Avalon-MM slave bus plus interrupt line of the timer block
interface ethernet_multi_timer_if
  import ethernet_timer_pkg::*;
#(
  parameter int ADDR_W = addr_w(4)
);
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/ethernet_multi_timer_channel.sv
// rtl/ethernet_multi_timer_channel.sv - one down-counting interval timer with prescaler, RUN/TO flags and snapshot
module ethernet_timer_channel
  import ethernet_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PSC_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h30D3F
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_status_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_period_i,
  input  logic             wr_snap_i,
  input  logic             wr_psc_i,
  input  logic [3:0]       ctrl_wdata_i,
  input  logic [CNT_W-1:0] period_wdata_i,
  input  logic [PSC_W-1:0] psc_wdata_i,
  output logic             run_o,
  output logic             to_o,
  output logic             cont_o,
  output logic             ito_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] snapshot_o,
  output logic [PSC_W-1:0] prescale_o
);
  localparam logic [CNT_W-1:0] RST_PER = RESET_PERIOD[CNT_W-1:0];

  logic             run_q, run_d;
  logic             to_q, to_d;
  logic             cont_q, cont_d;
  logic             ito_q, ito_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [PSC_W-1:0] prescale_q, prescale_d;
  logic [PSC_W-1:0] psc_q, psc_d;

  logic start, stop, tick, at_zero, timeout;

  assign start   = wr_ctrl_i && ctrl_wdata_i[CTRL_START];
  assign stop    = wr_ctrl_i && ctrl_wdata_i[CTRL_STOP];
  assign tick    = run_q && (psc_q == prescale_q);
  assign at_zero = (counter_q == '0);
  // zero_q remembers counter==0 at the previous tick, so a held zero raises only one event.
  assign timeout = tick && at_zero && !zero_q;

  always_comb begin
    run_d      = run_q;
    to_d       = to_q;
    cont_d     = cont_q;
    ito_d      = ito_q;
    zero_d     = zero_q;
    period_d   = period_q;
    counter_d  = counter_q;
    snap_d     = snap_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;

    if (wr_ctrl_i) begin
      cont_d = ctrl_wdata_i[CTRL_CONT];
      ito_d  = ctrl_wdata_i[CTRL_ITO];
    end
    if (wr_psc_i)  prescale_d = psc_wdata_i;
    if (wr_snap_i) snap_d     = counter_q;

    if (start || wr_period_i || tick) psc_d = '0;
    else if (run_q)                   psc_d = psc_q + 1'b1;

    if (wr_period_i) begin
      period_d  = period_wdata_i;
      counter_d = period_wdata_i;
      zero_d    = 1'b0;
    end else if (tick) begin
      zero_d = at_zero;
      if (!at_zero)                 counter_d = counter_q - 1'b1;
      else if (!(timeout && !cont_q)) counter_d = period_q;
    end

    if (start)                                          run_d = 1'b1;
    else if (stop || wr_period_i || (timeout && !cont_q)) run_d = 1'b0;

    // A timeout coinciding with a STATUS write must not be lost.
    if (timeout)          to_d = 1'b1;
    else if (wr_status_i) to_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      cont_q     <= 1'b0;
      ito_q      <= 1'b0;
      zero_q     <= 1'b0;
      period_q   <= RST_PER;
      counter_q  <= RST_PER;
      snap_q     <= '0;
      prescale_q <= '0;
      psc_q      <= '0;
    end else begin
      run_q      <= run_d;
      to_q       <= to_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
      zero_q     <= zero_d;
      period_q   <= period_d;
      counter_q  <= counter_d;
      snap_q     <= snap_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
    end
  end

  assign run_o      = run_q;
  assign to_o       = to_q;
  assign cont_o     = cont_q;
  assign ito_o      = ito_q;
  assign period_o   = period_q;
  assign snapshot_o = snap_q;
  assign prescale_o = prescale_q;

endmodule

// File: rtl/ethernet_multi_timer.sv
// rtl/ethernet_multi_timer.sv - NUM_CH interval timers behind one Avalon-MM slave with combined irq
module ethernet_multi_timer
  import ethernet_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PSC_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h30D3F
) (
  input logic                   clk,
  input logic                   reset_n,
  ethernet_multi_timer_if.slave bus
);
  localparam int ADDR_W = addr_w(NUM_CH);

  logic [2:0]        reg_sel;
  logic [ADDR_W-1:0] ch_sel;
  logic              wr_en;
  logic              unused_wdata;

  assign reg_sel      = bus.address[2:0];
  assign ch_sel       = bus.address >> 3;
  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;

  logic [NUM_CH-1:0] run_v, to_v, cont_v, ito_v, pend_v;
  logic [CNT_W-1:0]  period_a [NUM_CH];
  logic [CNT_W-1:0]  snap_a   [NUM_CH];
  logic [PSC_W-1:0]  psc_a    [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = wr_en && (ch_sel == ADDR_W'(g));

    ethernet_timer_channel #(
      .CNT_W        (CNT_W),
      .PSC_W        (PSC_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .wr_status_i    (hit && (reg_sel == REG_STATUS)),
      .wr_ctrl_i      (hit && (reg_sel == REG_CTRL)),
      .wr_period_i    (hit && (reg_sel == REG_PERIOD)),
      .wr_snap_i      (hit && (reg_sel == REG_SNAPSHOT)),
      .wr_psc_i       (hit && (reg_sel == REG_PRESCALE)),
      .ctrl_wdata_i   (bus.writedata[3:0]),
      .period_wdata_i (bus.writedata[CNT_W-1:0]),
      .psc_wdata_i    (bus.writedata[PSC_W-1:0]),
      .run_o          (run_v[g]),
      .to_o           (to_v[g]),
      .cont_o         (cont_v[g]),
      .ito_o          (ito_v[g]),
      .period_o       (period_a[g]),
      .snapshot_o     (snap_a[g]),
      .prescale_o     (psc_a[g])
    );
  end

  assign pend_v = to_v & ito_v;

  logic [31:0] readdata_d, readdata_q;

  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) begin
        case (reg_sel)
          REG_STATUS: begin
            readdata_d[STAT_RUN] = run_v[i];
            readdata_d[STAT_TO]  = to_v[i];
          end
          REG_CTRL: begin
            readdata_d[CTRL_CONT] = cont_v[i];
            readdata_d[CTRL_ITO]  = ito_v[i];
          end
          REG_PERIOD:   readdata_d = 32'(period_a[i]);
          REG_SNAPSHOT: readdata_d = 32'(snap_a[i]);
          REG_PRESCALE: readdata_d = 32'(psc_a[i]);
          REG_IRQ_PEND: if (i == 0) readdata_d = 32'(pend_v);
          default:      readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |pend_v;

endmodule
